// File: rtl/super_mode_sequencer_if.sv
// Mode-sequencer request/status bundle.
// master drives the requests, slave is the sequencer.
interface super_mode_sequencer_if;
  logic       btn_turbo_toggle;
  logic       btn_reset_req;
  logic       sw_turbo_we;
  logic       sw_turbo_val;
  logic       sw_reset_req;
  logic       wdt_reset_req;
  logic       safe_mode;
  logic       quiesce_ack;
  logic       quiesce_req;
  logic       cpu_reset;
  logic       turbo_enabled;
  logic [1:0] reset_cause;
  logic       busy;

  modport master (
    output btn_turbo_toggle, btn_reset_req,
    output sw_turbo_we, sw_turbo_val,
    output sw_reset_req, wdt_reset_req,
    output safe_mode, quiesce_ack,
    input  quiesce_req, cpu_reset,
    input  turbo_enabled, reset_cause, busy
  );

  modport slave (
    input  btn_turbo_toggle, btn_reset_req,
    input  sw_turbo_we, sw_turbo_val,
    input  sw_reset_req, wdt_reset_req,
    input  safe_mode, quiesce_ack,
    output quiesce_req, cpu_reset,
    output turbo_enabled, reset_cause, busy
  );
endinterface

// File: rtl/super_mode_sequencer.sv
// System mode sequencer: arbitrates reset and turbo changes
// behind a bus-quiesce handshake.
module super_mode_sequencer #(
  parameter int RESET_CYCLES    = 16,
  parameter int HOLDOFF_CYCLES  = 64,
  parameter int QUIESCE_TIMEOUT = 1024,
  parameter bit TURBO_DEFAULT   = 1'b1
) (
  input logic clk,
  input logic rst,
  super_mode_sequencer_if.slave bus
);

  localparam int M1 = (RESET_CYCLES > HOLDOFF_CYCLES)
                      ? RESET_CYCLES : HOLDOFF_CYCLES;
  localparam int MAXC = (M1 > QUIESCE_TIMEOUT)
                        ? M1 : QUIESCE_TIMEOUT;
  localparam int CW = $clog2(MAXC);
  localparam logic [CW-1:0] RA_END = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] RH_END = CW'(HOLDOFF_CYCLES - 1);
  localparam logic [CW-1:0] Q_END  = CW'(QUIESCE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, RQ, RA, RH, TQ, TS
  } state_t;

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic        turbo, turbo_n;
  logic [1:0]  cause, cause_n;
  logic        rst_pend, rst_pend_n;
  logic [1:0]  pcause, pcause_n;
  logic        trb_pend, trb_pend_n;
  logic        target, target_n;

  logic        rst_in, rst_any;
  logic [1:0]  cause_in, cause_any;
  logic        trb_in, trb_any, trb_ok;
  logic        tgt_base, tgt_in, tgt_any;

  assign rst_in = bus.wdt_reset_req | bus.sw_reset_req
                | bus.btn_reset_req;
  assign cause_in = bus.wdt_reset_req ? 2'b11 :
                    bus.sw_reset_req  ? 2'b10 : 2'b01;
  assign rst_any = rst_pend | rst_in;
  // a latched cause only survives if it outranks a new one
  assign cause_any = (rst_pend && (!rst_in || pcause > cause_in))
                     ? pcause : cause_in;

  assign tgt_base = trb_pend ? target : turbo;
  assign trb_in   = bus.sw_turbo_we | bus.btn_turbo_toggle;
  assign tgt_in   = bus.sw_turbo_we ? bus.sw_turbo_val : ~tgt_base;
  assign trb_any  = trb_pend | trb_in;
  assign tgt_any  = trb_in ? tgt_in : target;
  assign trb_ok   = trb_any & ~(bus.safe_mode & tgt_any);

  always_comb begin
    state_n    = state;
    turbo_n    = turbo & ~bus.safe_mode;
    cause_n    = cause;
    rst_pend_n = rst_pend;
    pcause_n   = pcause;
    trb_pend_n = trb_pend;
    target_n   = target;
    unique case (state)
      IDLE: begin
        if (rst_any) begin
          state_n    = RQ;
          cause_n    = cause_any;
          rst_pend_n = 1'b0;
          trb_pend_n = 1'b0;
        end else if (trb_ok && tgt_any != turbo) begin
          state_n    = TQ;
          trb_pend_n = 1'b1;
          target_n   = tgt_any;
        end else begin
          trb_pend_n = 1'b0;
        end
      end
      RQ: begin
        trb_pend_n = 1'b0;
        rst_pend_n = 1'b0;
        if (bus.quiesce_ack || cnt == Q_END) state_n = RA;
      end
      TQ: begin
        if (rst_in) begin
          state_n    = RQ;
          cause_n    = cause_in;
          trb_pend_n = 1'b0;
        end else begin
          if (trb_in) begin
            trb_pend_n = 1'b1;
            target_n   = tgt_in;
          end
          if (bus.quiesce_ack) begin
            state_n = TS;
          end else if (cnt == Q_END) begin
            state_n    = IDLE;
            trb_pend_n = 1'b0;
          end
        end
      end
      RA: begin
        trb_pend_n = 1'b0;
        rst_pend_n = 1'b0;
        if (cnt == RA_END) begin
          state_n = RH;
          turbo_n = TURBO_DEFAULT & ~bus.safe_mode;
        end
      end
      RH: begin
        trb_pend_n = 1'b0;
        rst_pend_n = 1'b0;
        if (cnt == RH_END) state_n = IDLE;
      end
      TS: begin
        state_n    = IDLE;
        turbo_n    = target & ~bus.safe_mode;
        trb_pend_n = trb_in;
        if (trb_in) target_n = tgt_in;
        if (rst_in) begin
          rst_pend_n = 1'b1;
          pcause_n   = cause_in;
        end
      end
      default: state_n = IDLE;
    endcase
    if (bus.safe_mode && target_n) trb_pend_n = 1'b0;
  end

  always_comb begin
    cnt_n = cnt;
    if (state_n != state) cnt_n = '0;
    else if (cnt != '1)   cnt_n = cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RA;
      cnt      <= '0;
      turbo    <= 1'b0;
      cause    <= 2'b00;
      rst_pend <= 1'b0;
      pcause   <= 2'b00;
      trb_pend <= 1'b0;
      target   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      turbo    <= turbo_n;
      cause    <= cause_n;
      rst_pend <= rst_pend_n;
      pcause   <= pcause_n;
      trb_pend <= trb_pend_n;
      target   <= target_n;
    end
  end

  assign bus.quiesce_req   = (state == RQ) || (state == TQ);
  assign bus.cpu_reset     = (state == RA);
  assign bus.busy          = (state != IDLE);
  assign bus.turbo_enabled = turbo;
  assign bus.reset_cause   = cause;

endmodule

// File: tb/tb_super_mode_sequencer.sv
// Bench for super_mode_sequencer: expected output changes
// are queued with their cycle; a monitor checks each change.
module tb_super_mode_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   r, n, m;

  int         q_c[$];
  logic [5:0] q_v[$];
  string      q_n[$];
  logic [5:0] prev = 'x;
  logic [5:0] cur;

  super_mode_sequencer_if sif();

  super_mode_sequencer #(
    .RESET_CYCLES(16),
    .HOLDOFF_CYCLES(64),
    .QUIESCE_TIMEOUT(1024),
    .TURBO_DEFAULT(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(sif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {quiesce_req, cpu_reset, turbo_enabled, busy, reset_cause}
  always @(negedge clk) begin
    cur = {sif.quiesce_req, sif.cpu_reset, sif.turbo_enabled,
           sif.busy, sif.reset_cause};
    if (cur !== prev) begin
      prev = cur;
      n_cmp++;
      if (q_c.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change: cyc=%0d got=%b want=none",
                 cyc, cur);
      end else begin
        int         ec;
        logic [5:0] ev;
        string      en;
        ec = q_c.pop_front();
        ev = q_v.pop_front();
        en = q_n.pop_front();
        if (ec != cyc || ev !== cur) begin
          n_bad++;
          $display("FAIL %s: got cyc=%0d val=%b, want cyc=%0d val=%b",
                   en, cyc, cur, ec, ev);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic expect_at(input int c, input logic [5:0] v,
                           input string nm);
    q_c.push_back(c);
    q_v.push_back(v);
    q_n.push_back(nm);
  endtask

  task automatic drive(input logic bt, input logic br,
                       input logic sw, input logic sv,
                       input logic sr, input logic wr);
    sif.btn_turbo_toggle = bt;
    sif.btn_reset_req    = br;
    sif.sw_turbo_we      = sw;
    sif.sw_turbo_val     = sv;
    sif.sw_reset_req     = sr;
    sif.wdt_reset_req    = wr;
    tick();
    sif.btn_turbo_toggle = 1'b0;
    sif.btn_reset_req    = 1'b0;
    sif.sw_turbo_we      = 1'b0;
    sif.sw_turbo_val     = 1'b0;
    sif.sw_reset_req     = 1'b0;
    sif.wdt_reset_req    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time=%0t want=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sif.btn_turbo_toggle = 1'b0;
    sif.btn_reset_req    = 1'b0;
    sif.sw_turbo_we      = 1'b0;
    sif.sw_turbo_val     = 1'b0;
    sif.sw_reset_req     = 1'b0;
    sif.wdt_reset_req    = 1'b0;
    sif.safe_mode        = 1'b0;
    sif.quiesce_ack      = 1'b1;

    // power-on pass
    tick();
    expect_at(cyc, 6'b0_1_0_1_00, "por_reset");
    tick();
    tick();
    rst = 1'b0;
    r = cyc;
    expect_at(r + 16, 6'b0_0_1_1_00, "por_holdoff");
    expect_at(r + 80, 6'b0_0_1_0_00, "por_idle");
    wait_until(r + 85);

    // button toggle latency, turbo 1 -> 0
    n = cyc;
    expect_at(n + 1, 6'b1_0_1_1_00, "tgl_tq");
    expect_at(n + 2, 6'b0_0_1_1_00, "tgl_ts");
    expect_at(n + 3, 6'b0_0_0_0_00, "tgl_idle");
    drive(1, 0, 0, 0, 0, 0);
    wait_until(n + 8);

    // software write turbo 0 -> 1
    n = cyc;
    expect_at(n + 1, 6'b1_0_0_1_00, "sw1_tq");
    expect_at(n + 2, 6'b0_0_0_1_00, "sw1_ts");
    expect_at(n + 3, 6'b0_0_1_0_00, "sw1_idle");
    drive(0, 0, 1, 1, 0, 0);
    wait_until(n + 8);

    // sw write 0 beats a coincident button toggle
    n = cyc;
    expect_at(n + 1, 6'b1_0_1_1_00, "swbtn_tq");
    expect_at(n + 2, 6'b0_0_1_1_00, "swbtn_ts");
    expect_at(n + 3, 6'b0_0_0_0_00, "swbtn_idle");
    drive(1, 0, 1, 0, 0, 0);
    wait_until(n + 12);

    // btn+wdt reset, ack stuck low -> forced RA
    sif.quiesce_ack = 1'b0;
    n = cyc;
    expect_at(n + 1,    6'b1_0_0_1_11, "wdt_rq");
    expect_at(n + 1025, 6'b0_1_0_1_11, "wdt_ra_timeout");
    expect_at(n + 1041, 6'b0_0_1_1_11, "wdt_holdoff");
    expect_at(n + 1105, 6'b0_0_1_0_11, "wdt_idle");
    drive(0, 1, 0, 0, 0, 1);
    wait_until(n + 1110);

    // sw reset while waiting in TQ
    n = cyc;
    m = n + 5;
    expect_at(n + 1,  6'b1_0_1_1_11, "tq_wait");
    expect_at(m + 1,  6'b1_0_1_1_10, "tq_to_rq");
    expect_at(m + 2,  6'b0_1_1_1_10, "tq_ra");
    expect_at(m + 18, 6'b0_0_1_1_10, "tq_holdoff");
    expect_at(m + 82, 6'b0_0_1_0_10, "tq_idle");
    drive(1, 0, 0, 0, 0, 0);
    wait_until(m);
    drive(0, 0, 0, 0, 1, 0);
    sif.quiesce_ack = 1'b1;
    wait_until(m + 90);

    // safe mode clears turbo and blocks a target of 1
    n = cyc;
    expect_at(n + 1, 6'b0_0_0_0_10, "safe_clear");
    sif.safe_mode = 1'b1;
    tick();
    tick();
    drive(0, 0, 1, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    wait_until(n + 15);
    sif.safe_mode = 1'b0;

    // turbo quiesce timeout drops the request
    sif.quiesce_ack = 1'b0;
    tick();
    n = cyc;
    expect_at(n + 1,    6'b1_0_0_1_10, "tq_to_wait");
    expect_at(n + 1025, 6'b0_0_0_0_10, "tq_to_idle");
    drive(1, 0, 0, 0, 0, 0);
    wait_until(n + 1030);

    // rst mid-sequence aborts to reset values
    n = cyc;
    expect_at(n + 1, 6'b1_0_0_1_10, "abort_tq");
    expect_at(n + 3, 6'b0_1_0_1_00, "abort_rst");
    drive(1, 0, 0, 0, 0, 0);
    wait_until(n + 3);
    rst = 1'b1;
    wait_until(n + 8);

    n_cmp++;
    if (q_c.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: got %0d pending, want 0",
               q_c.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
